cpu: RTL and testbench

//  16-bit multicycle load/store CPU with 16 x 16-bit registers and separate instruction and data ports (Harvard).

---
 rtl/cpu.sv | 181 ++++++++++++++++++
 tb/tb_cpu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// 16-bit multicycle Harvard load/store CPU.
// Four-state sequencer (IF, EX, MEM, WB), sixteen general-purpose registers,
// Z/N flags, a registered data address and a tri-stated data bus that is
// driven only during the MEM cycle of a store.
module cpu (
  input  logic        CK,
  input  logic        RST,
  output logic [15:0] IA,
  input  logic [15:0] ID,
  output logic [15:0] DA,
  inout  wire  [15:0] DD,
  output logic        RW
);

  typedef enum logic [1:0] {
    S_IF  = 2'd0,
    S_EX  = 2'd1,
    S_MEM = 2'd2,
    S_WB  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] da_q, da_d;
  logic        rw_q, rw_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic [15:0] regs_q [16];
  logic [15:0] regs_d [16];

  // Datapath holding registers; their contents only matter once the
  // sequencer has passed through the state that loads them.
  logic [15:0] ir_q, ir_d;
  logic [15:0] res_q, res_d;
  logic [15:0] dout_q, dout_d;
  logic        take_q, take_d;

  logic [3:0]  op, fa, fb, fc;
  logic [15:0] rb_val, rc_val;
  logic        is_alu, is_jmp, is_br, is_st, is_ld, is_imm;

  function automatic logic [15:0] alu_f(input logic [2:0] sel,
                                        input logic [15:0] b,
                                        input logic [15:0] c);
    logic [15:0] r;
    case (sel)
      3'd0:    r = b + c;
      3'd1:    r = b - c;
      3'd2:    r = b & c;
      3'd3:    r = b | c;
      3'd4:    r = b ^ c;
      3'd5:    r = ~b;
      3'd6:    r = {b[14:0], 1'b0};
      default: r = {1'b0, b[15:1]};
    endcase
    return r;
  endfunction

  // Branch conditions 4..15 are defined as never taken.
  function automatic logic br_cond_f(input logic [3:0] cond,
                                     input logic z,
                                     input logic n);
    logic t;
    case (cond)
      4'd0:    t = z;
      4'd1:    t = ~z;
      4'd2:    t = n;
      4'd3:    t = 1'b1;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign op     = ir_q[15:12];
  assign fa     = ir_q[11:8];
  assign fb     = ir_q[7:4];
  assign fc     = ir_q[3:0];
  assign rb_val = regs_q[fb];
  assign rc_val = regs_q[fc];

  assign is_alu = (op[3] == 1'b0);
  assign is_jmp = (op == 4'b1000);
  assign is_br  = (op == 4'b1001);
  assign is_st  = (op == 4'b1010);
  assign is_ld  = (op == 4'b1011);
  assign is_imm = (op == 4'b1100);

  assign IA = pc_q;
  assign DA = da_q;
  assign RW = rw_q;
  assign DD = rw_q ? 16'hzzzz : dout_q;

  // Sequencer next-state and datapath updates, one state per clock.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    da_d    = da_q;
    rw_d    = rw_q;
    z_d     = z_q;
    n_d     = n_q;
    ir_d    = ir_q;
    res_d   = res_q;
    dout_d  = dout_q;
    take_d  = take_q;
    regs_d  = regs_q;
    case (state_q)
      S_IF: begin
        ir_d    = ID;
        state_d = S_EX;
      end
      S_EX: begin
        take_d  = 1'b0;
        state_d = S_WB;
        if (is_alu) begin
          res_d = alu_f(op[2:0], rb_val, rc_val);
        end else if (is_imm) begin
          res_d = {8'h00, ir_q[7:0]};
        end else if (is_jmp) begin
          res_d  = rc_val;
          take_d = 1'b1;
        end else if (is_br) begin
          res_d  = rc_val;
          take_d = br_cond_f(fa, z_q, n_q);
        end else if (is_ld || is_st) begin
          da_d    = rc_val;
          state_d = S_MEM;
          if (is_st) begin
            rw_d   = 1'b0;
            dout_d = rb_val;
          end
        end
      end
      S_MEM: begin
        // Memory responds on this cycle's falling edge; load data is
        // captured and the write strobe released at the closing edge.
        if (is_ld) res_d = DD;
        rw_d    = 1'b1;
        state_d = S_WB;
      end
      default: begin
        if (is_alu || is_imm || is_ld) regs_d[fa] = res_q;
        if (is_alu) begin
          z_d = (res_q == 16'h0000);
          n_d = res_q[15];
        end
        pc_d    = take_q ? res_q : pc_q + 16'd1;
        state_d = S_IF;
      end
    endcase
  end

  // Architectural state and bus control, cleared asynchronously.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IF;
      pc_q    <= 16'h0000;
      da_q    <= 16'h0000;
      rw_q    <= 1'b1;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      da_q    <= da_d;
      rw_q    <= rw_d;
      z_q     <= z_d;
      n_q     <= n_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Instruction, result and store-data holding registers.
  always_ff @(posedge CK) begin
    ir_q   <= ir_d;
    res_q  <= res_d;
    dout_q <= dout_d;
    take_q <= take_d;
  end

endmodule

// File: tb/tb_cpu.sv
// Testbench for cpu: behavioural instruction/data memories that update on
// the falling edge, a store/fetch scoreboard fed by directed programs, and a
// monitor that compares every store cycle and instruction fetch.
module tb_cpu;

  logic        CK;
  logic        RST;
  logic [15:0] IA;
  logic [15:0] ID;
  logic [15:0] DA;
  wire  [15:0] dd_bus;
  logic        RW;

  cpu dut (
    .CK (CK),
    .RST(RST),
    .IA (IA),
    .ID (ID),
    .DA (DA),
    .DD (dd_bus),
    .RW (RW)
  );

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];
  logic [15:0] rd_q;
  logic        mem_clr;

  assign dd_bus = RW ? rd_q : 16'hzzzz;

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // Both memories present new data on the falling edge.
  always @(negedge CK) begin
    ID <= imem[IA[7:0]];
    if (mem_clr) begin
      for (int i = 0; i < 256; i++)
        dmem[i] <= (i == 0) ? 16'd5 : (i == 1) ? 16'd15 : 16'd0;
    end else if (RW === 1'b0) begin
      dmem[DA[7:0]] <= dd_bus;
    end
    rd_q <= dmem[DA[7:0]];
  end

  typedef struct packed { logic [15:0] da; logic [15:0] dd; } st_t;
  typedef struct packed { logic [15:0] ia; logic [7:0] hold; } fe_t;

  st_t         st_q[$];
  fe_t         fe_q[$];
  logic [15:0] rst_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int drain_req = 0;
  int drain_seen = 0;
  int tmo_req = 0;
  int tmo_seen = 0;
  logic [15:0] last_ia = 16'h0000;
  int hold = 0;

  // Monitor: compares stores, fetches, reset state and end-of-program drains.
  always @(negedge CK) begin : monitor
    st_t es;
    fe_t ef;
    logic [15:0] ca;
    if (tmo_req != tmo_seen) begin
      n_cmp++; n_bad++;
      $display("FAIL st_wait: no RW=0 cycle seen, required one within budget");
      tmo_seen = tmo_req;
    end
    if (drain_req != drain_seen) begin
      n_cmp++;
      if (st_q.size() != 0) begin
        n_bad++;
        $display("FAIL st_drain: %0d stores outstanding, required 0", st_q.size());
        st_q.delete();
      end
      n_cmp++;
      if (fe_q.size() != 0) begin
        n_bad++;
        $display("FAIL fe_drain: %0d fetches outstanding, required 0", fe_q.size());
        fe_q.delete();
      end
      drain_seen = drain_req;
    end
    if (RST !== 1'b1) begin
      last_ia = 16'h0000;
      hold    = 0;
      if (rst_q.size() > 0) begin
        ca = rst_q.pop_front();
        n_cmp++;
        if (RW !== 1'b1) begin
          n_bad++; $display("FAIL rst_rw: got %b, required 1", RW);
        end
        n_cmp++;
        if (DA !== 16'h0000) begin
          n_bad++; $display("FAIL rst_da: got %h, required 0000", DA);
        end
        n_cmp++;
        if (IA !== 16'h0000) begin
          n_bad++; $display("FAIL rst_ia: got %h, required 0000", IA);
        end
        n_cmp++;
        if (dmem[ca[7:0]] !== 16'h0000) begin
          n_bad++;
          $display("FAIL st_cancel: MEM[%h] got %h, required 0000", ca, dmem[ca[7:0]]);
        end
      end
    end else begin
      if (RW === 1'b0) begin
        n_cmp++;
        if (st_q.size() == 0) begin
          n_bad++;
          $display("FAIL st_extra: DA=%h DD=%h, required no store", DA, dd_bus);
        end else begin
          es = st_q.pop_front();
          if (DA !== es.da || dd_bus !== es.dd) begin
            n_bad++;
            $display("FAIL st_data: DA=%h DD=%h, required DA=%h DD=%h", DA, dd_bus, es.da, es.dd);
          end
        end
      end
      if (IA === last_ia) begin
        hold++;
      end else begin
        if (fe_q.size() > 0) begin
          ef = fe_q.pop_front();
          n_cmp++;
          if (IA !== ef.ia || hold != int'(ef.hold)) begin
            n_bad++;
            $display("FAIL fetch: IA=%h after %0d cycles, required IA=%h after %0d",
                     IA, hold, ef.ia, ef.hold);
          end
        end
        last_ia = IA;
        hold    = 1;
      end
    end
  end

  task automatic exp_st(input logic [15:0] a, input logic [15:0] d);
    st_t e;
    e.da = a; e.dd = d;
    st_q.push_back(e);
  endtask

  task automatic exp_fe(input logic [15:0] a, input logic [7:0] h);
    fe_t e;
    e.ia = a; e.hold = h;
    fe_q.push_back(e);
  endtask

  task automatic w(input int a, input logic [15:0] v);
    imem[a] = v;
  endtask

  // Hold the CPU in reset and fill unused instruction slots with a store
  // of R0, so any stray control transfer shows up as an unexpected store.
  task automatic prog_begin();
    @(posedge CK);
    #2 RST = 1'b0;
    rst_q.push_back(16'h00FF);
    for (int i = 0; i < 256; i++) imem[i] = 16'hA000;
  endtask

  task automatic prog_go(input int n);
    repeat (2) @(posedge CK);
    #2 RST = 1'b1;
    repeat (n) @(posedge CK);
    drain_req++;
    @(negedge CK);
    #1;
  endtask

  initial begin
    bit found;
    RST = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 16'hA000;
    repeat (2) @(posedge CK);
    #2 mem_clr = 1'b0;

    // IMM/IMM/ADD, store R3, BR Z not taken (Z=0), then a two-word idle loop.
    prog_begin();
    w(0, 16'hC105); w(1, 16'hC2FF); w(2, 16'h0312); w(3, 16'hC010);
    w(4, 16'hA030); w(5, 16'hC520); w(6, 16'h9005); w(7, 16'hC607);
    w(8, 16'h8006);
    exp_st(16'h0010, 16'h0104);
    exp_fe(1, 3); exp_fe(2, 3); exp_fe(3, 3); exp_fe(4, 3); exp_fe(5, 4);
    exp_fe(6, 3); exp_fe(7, 3); exp_fe(8, 3); exp_fe(7, 3);
    prog_go(60);

    // 0-1 gives FFFF with N=1, Z=0: BR Z falls through, BR N jumps to 0x0A.
    prog_begin();
    w(0, 16'hC409); w(1, 16'hC60A); w(2, 16'hC100); w(3, 16'hC201);
    w(4, 16'h1312); w(5, 16'h9004); w(6, 16'h9206); w(7, 16'hC0EE);
    w(10, 16'hC730); w(11, 16'hA037); w(12, 16'hC80D); w(13, 16'h8008);
    exp_st(16'h0030, 16'hFFFF);
    prog_go(80);

    // Equal operands give Z=1; the IMM in between leaves flags alone.
    prog_begin();
    w(0, 16'hC107); w(1, 16'hC207); w(2, 16'h1312); w(3, 16'hC50D);
    w(4, 16'h9005); w(13, 16'hC940); w(14, 16'hA039); w(15, 16'hC80F);
    w(16, 16'h8008);
    exp_st(16'h0040, 16'h0000);
    exp_fe(1, 3); exp_fe(2, 3); exp_fe(3, 3); exp_fe(4, 3); exp_fe(13, 3);
    exp_fe(14, 3); exp_fe(15, 4); exp_fe(16, 3); exp_fe(15, 3);
    prog_go(80);

    // Multiply 5 x 15 by repeated addition, result stored to MEM[2].
    prog_begin();
    w(0, 16'hB200); w(1, 16'hC001); w(2, 16'hB400); w(3, 16'hC501);
    w(4, 16'hC60B); w(5, 16'hC707); w(6, 16'hC100); w(7, 16'h0112);
    w(8, 16'h1445); w(9, 16'h9006); w(10, 16'h8007); w(11, 16'hC802);
    w(12, 16'hA018); w(13, 16'hC90D); w(14, 16'h8009);
    exp_st(16'h0002, 16'h004B);
    prog_go(300);

    // Reset during the MEM cycle of a store, then the same program in full:
    // store, load-back of the same address, opcode 1111 as NOP, store again.
    prog_begin();
    mem_clr = 1'b1;
    w(0, 16'hC1AB); w(1, 16'hC250); w(2, 16'hA012); w(3, 16'hB302);
    w(4, 16'hF123); w(5, 16'hC460); w(6, 16'hA034); w(7, 16'hC707);
    w(8, 16'h8007);
    repeat (2) @(posedge CK);
    #2 mem_clr = 1'b0;
    RST = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge CK);
      #1;
      if (RW === 1'b0) found = 1'b1;
    end
    if (!found) tmo_req++;
    #1 RST = 1'b0;
    rst_q.push_back(16'h0050);
    exp_st(16'h0050, 16'h00AB);
    exp_st(16'h0060, 16'h00AB);
    exp_fe(1, 3); exp_fe(2, 3); exp_fe(3, 4); exp_fe(4, 4); exp_fe(5, 3);
    exp_fe(6, 3); exp_fe(7, 4); exp_fe(8, 3); exp_fe(7, 3);
    prog_go(80);

    // Logic and shift ops, plus a register used as both source and destination.
    prog_begin();
    w(0, 16'hC1F0); w(1, 16'hC23C); w(2, 16'h2312); w(3, 16'h3412);
    w(4, 16'h4512); w(5, 16'h5610); w(6, 16'h7710); w(7, 16'h6860);
    w(8, 16'hC980); w(9, 16'hA039); w(10, 16'hC981); w(11, 16'hA049);
    w(12, 16'hC982); w(13, 16'hA059); w(14, 16'hC983); w(15, 16'hA069);
    w(16, 16'hC984); w(17, 16'hA079); w(18, 16'hC985); w(19, 16'hA089);
    w(20, 16'h0111); w(21, 16'hC986); w(22, 16'hA019); w(23, 16'hCA17);
    w(24, 16'h800A);
    exp_st(16'h0080, 16'h0030); exp_st(16'h0081, 16'h00FC);
    exp_st(16'h0082, 16'h00CC); exp_st(16'h0083, 16'hFF0F);
    exp_st(16'h0084, 16'h0078); exp_st(16'h0085, 16'hFE1E);
    exp_st(16'h0086, 16'h01E0);
    prog_go(150);

    @(negedge CK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
